sipo_rx_ctrl: RTL
=================

Name: sipo_rx_ctrl

Overview:
- Receive controller that sequences a serial-in/parallel-out shift datapath for an asynchronous, start/stop-framed serial line.
- Detects the start bit, times mid-bit sampling with a clock divider, and drives the shift enable for N data bits.
- Checks the stop bit, then hands the assembled word to a one-entry output buffer with a valid/ready handshake.
- Sits between the pad-side serial input (already synchronised upstream) and the word-wide consumer.

Parameters:
N, 8, data bits per frame; legal range 2..32.
DIV, 4, clk cycles per serial bit; must be at least 2.
LSB_FIRST, 1, 1 = first data bit lands in word[0]; 0 = first data bit lands in word[N-1].

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
en  in  1  receiver enable; when low, the FSM is held in IDLE.
sin  in  1  serial line; idles high.
word_o  out  N  buffered received word.
valid_o  out  1  word_o holds an unconsumed word.
ready_i  in  1  consumer accepts; transfer occurs when valid_o and ready_i are both high on a clk edge.
busy_o  out  1  high in any FSM state other than IDLE.
ovf_o  out  1  sticky overflow flag; cleared only by rst.
ferr_o  out  1  one-cycle pulse on stop-bit error.

Behaviour:
- Reset: state=IDLE, word_o=0, valid_o=0, busy_o=0, ovf_o=0, ferr_o=0, shift register=0, divider and bit counters=0.
- Reset is honoured mid-frame: a partial word is discarded and no valid_o is asserted.
- Counter widths: divider is $clog2(DIV) bits; bit counter is $clog2(N+1) bits. Counters wrap only under FSM control.
- Define edge t0 as the edge at which the FSM is in IDLE with en=1 and sin=0.
- IDLE: at t0, go to START and clear the divider.
- START: at t0+DIV/2 (integer floor), re-sample sin.
  - sin=1: false start; return to IDLE with no flags.
  - sin=0: go to DATA and clear the divider and bit counter.
- DATA: data bit i (i=0..N-1) is sampled at t0+DIV/2+(i+1)*DIV.
  - Each sample raises a single-cycle shift enable to the datapath.
  - After bit N-1, go to STOP.
- STOP: the stop bit is sampled at t0+DIV/2+(N+1)*DIV.
  - sin=0: ferr_o pulses for one cycle, the word is discarded, go to IDLE.
  - sin=1: load the word into the output buffer, go to IDLE. valid_o rises on the following edge, so latency from the stop sample is 1 clk.
- Buffer load while valid_o is already high:
  - If ready_i is high in the same cycle, the old word transfers and the new word loads; valid_o stays 1 with no gap.
  - If ready_i is low, the new word is dropped, word_o is unchanged, and ovf_o is set.
- Handshake: word_o is stable while valid_o=1 and ready_i=0. valid_o falls on the edge after a transfer unless a new word loads in that same cycle.
- en low at any edge: the FSM returns to IDLE and any partial word is discarded. The output buffer and ovf_o are retained, and the consumer may still drain the buffer.
- Next frame: the FSM may leave IDLE on the edge immediately after a stop-bit sample if sin=0, giving back-to-back frames with no idle gap.
- ferr_o and the buffer load are mutually exclusive within a single frame.

Decomposition:
- Package sipo_rx_pkg:
  - state enum {IDLE, START, DATA, STOP}, 2-bit encoding.
  - Localparam helpers for divider and bit-counter widths.
  - HALF_BIT = DIV/2.
- Sub-module sipo_shift_reg, the datapath:
  - Parameters N, LSB_FIRST.
  - Ports clk, rst, shift_en, din, q[N-1:0].
  - Shifts only when shift_en is high; asynchronous reset clears q.
- The controller owns the FSM, counters, output buffer and flags.

Test Plan:
1. N=8, DIV=4, LSB_FIRST=1, ready_i=1; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> at t0+38 the stop bit is sampled; valid_o=1 with word_o=0xA5 at t0+39; transfer in that cycle; ovf_o=0, ferr_o=0.
2. Same setup, ready_i=0; send 0x3C then 0x81 back-to-back -> word_o stays 0x3C with valid_o held high; ovf_o=1 after the second stop bit. Then raise ready_i -> 0x3C transfers, valid_o=0.
3. Glitch: sin low for 1 cycle only, from IDLE -> START re-sample at t0+2 sees 1; return to IDLE; busy_o high for exactly 2 cycles; no valid_o, no ferr_o.
4. Frame error: send 0x55 with stop bit 0 -> ferr_o pulses for 1 cycle at t0+39; valid_o stays 0.
5. Assert rst at t0+20 (mid-DATA) for 1 cycle, then send a clean 0xF0 -> no output from the aborted frame; only 0xF0 appears; all outputs were 0 during reset.
6. LSB_FIRST=0, N=8; send serial bits 1,1,0,0,0,0,0,1 -> word_o=0xC1. Repeat with en dropped mid-frame -> FSM returns to IDLE and no word is produced.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared types and width helpers for the framed serial receive controller.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Divider width: enough bits to count one full serial bit period.
  function automatic int div_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  // Bit counter width: enough bits to hold 0..N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Offset from the start-bit edge to the middle of the bit.
  function automatic int half_bit(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift datapath; bit order chosen at elaboration.
module sipo_shift_reg #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         din,
  output logic [N-1:0] q
);

  // Shift one bit in per enable; after N shifts the first bit sits at the chosen end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      if (LSB_FIRST) q <= {din, q[N-1:1]};
      else           q <= {q[N-2:0], din};
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Receive controller: start detect, mid-bit sampling, stop check and a one-entry output buffer.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int N         = 8,
  parameter int DIV       = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sin,
  output logic [N-1:0] word_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o,
  output logic         ovf_o,
  output logic         ferr_o
);

  localparam int DW       = div_width(DIV);
  localparam int CW       = cnt_width(N);
  localparam int HALF_BIT = half_bit(DIV);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);

  rx_state_t     state, state_n;
  logic [DW-1:0] div_q, div_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          shift_en;
  logic          stop_ok, stop_bad;
  logic          load_pend, err_pend;
  logic [N-1:0]  shift_q;

  sipo_shift_reg #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (sin),
    .q        (shift_q)
  );

  assign busy_o = (state != IDLE);

  // State, divider and bit counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      div_q <= div_n;
      cnt_q <= cnt_n;
    end
  end

  // Frame sequencing: counters only advance or clear as the current state dictates.
  always_comb begin
    state_n  = state;
    div_n    = div_q;
    cnt_n    = cnt_q;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (!en) begin
      state_n = IDLE;
      div_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state_n = START;
            div_n   = '0;
          end
        end
        START: begin
          if (div_q == HALF_LAST) begin
            div_n = '0;
            if (sin) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              cnt_n   = '0;
            end
          end else begin
            div_n = div_q + 1'b1;
          end
        end
        DATA: begin
          if (div_q == DIV_LAST) begin
            shift_en = 1'b1;
            div_n    = '0;
            if (cnt_q == CNT_LAST) state_n = STOP;
            else                   cnt_n   = cnt_q + 1'b1;
          end else begin
            div_n = div_q + 1'b1;
          end
        end
        STOP: begin
          if (div_q == DIV_LAST) begin
            div_n   = '0;
            state_n = IDLE;
            if (sin) stop_ok  = 1'b1;
            else     stop_bad = 1'b1;
          end else begin
            div_n = div_q + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output buffer and flags, one edge behind the stop-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_pend <= 1'b0;
      err_pend  <= 1'b0;
      ferr_o    <= 1'b0;
      ovf_o     <= 1'b0;
      valid_o   <= 1'b0;
      word_o    <= '0;
    end else begin
      load_pend <= stop_ok;
      err_pend  <= stop_bad;
      ferr_o    <= err_pend;
      if (load_pend) begin
        if (!valid_o || ready_i) begin
          word_o  <= shift_q;
          valid_o <= 1'b1;
        end else begin
          ovf_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
